// File: rtl/sdram_pkg.sv
// Shared widths, limits and write-side FSM encoding for the SDRAM controller.
package sdram_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned LEN_W     = 10;
  localparam int unsigned MAX_BURST = 512;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBurst
  } wr_state_e;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO with registered read data, full flag, overflow pulse and fill count.
module sdram_sync_fifo #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Aw    = 10,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic [Aw:0]      count_o
);

  localparam logic [Aw:0] DepthCnt = (Aw+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Aw:0]      count_q, count_d;
  logic [Width-1:0] rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full && !flush_i;
  // An underflowing pop leaves pointer, count and read data untouched.
  assign do_pop  = pop_i && !empty && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    ovf_d   = push_i && full && !flush_i;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop) begin
        rptr_d  = rptr_q + 1'b1;
        rdata_d = mem_q[rptr_q];
      end
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign full_o  = full;
  assign ovf_o   = ovf_q;
  assign count_o = count_q;

endmodule

// File: rtl/sdram_wr_fifo_ctrl.sv
// Write-side front end: buffers user words and issues one burst request per buffered burst,
// advancing the SDRAM address inside a programmable wrap window.
module sdram_wr_fifo_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned FIFO_AW    = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               init_end,
  input  logic               usr_wr_en,
  input  logic [15:0]        usr_wr_data,
  output logic               usr_wr_full,
  output logic               usr_wr_ovf,
  output logic [FIFO_AW:0]   wr_fifo_num,
  input  logic [23:0]        wr_b_addr,
  input  logic [23:0]        wr_e_addr,
  input  logic [9:0]         wr_burst_len,
  input  logic               wr_addr_rst,
  output logic               sdram_wr_en,
  output logic [23:0]        sdram_wr_addr,
  output logic [9:0]         sdram_wr_len,
  output logic [15:0]        sdram_wr_data,
  input  logic               sdram_wr_ack,
  input  logic               sdram_wr_end
);

  wr_state_e         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_vld_q, addr_vld_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              pend_q, pend_d;
  logic              flush;
  logic              len_ok, fill_ok, wrap;
  logic [ADDR_W-1:0] cur_addr, next_addr;

  sdram_sync_fifo #(
    .Depth (FIFO_DEPTH),
    .Aw    (FIFO_AW),
    .Width (DATA_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .flush_i (flush),
    .push_i  (usr_wr_en),
    .wdata_i (usr_wr_data),
    .pop_i   (sdram_wr_ack),
    .rdata_o (sdram_wr_data),
    .full_o  (usr_wr_full),
    .ovf_o   (usr_wr_ovf),
    .count_o (wr_fifo_num)
  );

  // Until first loaded, the address follows wr_b_addr; avoids an async load from an input.
  assign cur_addr  = addr_vld_q ? addr_q : wr_b_addr;
  assign next_addr = cur_addr + ADDR_W'(len_q);
  assign wrap      = ({1'b0, next_addr} + (ADDR_W+1)'(len_q)) > {1'b0, wr_e_addr};
  assign len_ok    = (wr_burst_len >= LEN_W'(2)) && (wr_burst_len <= LEN_W'(MAX_BURST));
  assign fill_ok   = wr_fifo_num >= (FIFO_AW+1)'(wr_burst_len);

  always_comb begin
    state_d    = state_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    len_d      = len_q;
    pend_d     = pend_q;
    flush      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_addr_rst) begin
          flush      = 1'b1;
          addr_d     = wr_b_addr;
          addr_vld_d = 1'b1;
        end else if (init_end && len_ok && fill_ok) begin
          state_d    = StReq;
          wr_en_d    = 1'b1;
          len_d      = wr_burst_len;
          addr_d     = cur_addr;
          addr_vld_d = 1'b1;
        end
      end
      StReq: begin
        if (wr_addr_rst) pend_d = 1'b1;
        if (sdram_wr_ack) begin
          wr_en_d = 1'b0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (wr_addr_rst) pend_d = 1'b1;
        if (sdram_wr_end) begin
          state_d    = StIdle;
          pend_d     = 1'b0;
          addr_vld_d = 1'b1;
          if (pend_q || wr_addr_rst) begin
            flush  = 1'b1;
            addr_d = wr_b_addr;
          end else begin
            addr_d = wrap ? wr_b_addr : next_addr;
          end
        end
      end
      default: begin
        state_d = StIdle;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      len_q      <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
    end
  end

  assign sdram_wr_en   = wr_en_q;
  assign sdram_wr_addr = cur_addr;
  assign sdram_wr_len  = len_q;

endmodule
